// File: rtl/key_expansion_if.sv
// Handshake bundle between the AES-128 key schedule and its round-key consumer.
interface key_expansion_if;
    logic         start;
    logic [127:0] cipher_key;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    modport master (
        output start, cipher_key, key_ready,
        input  round_key, round_idx, key_valid, busy, done
    );

    modport slave (
        input  start, cipher_key, key_ready,
        output round_key, round_idx, key_valid, busy, done
    );
endinterface

// File: rtl/key_expansion_iter.sv
// Iterative AES-128 key schedule: emits round keys 0..NR, one per accepted valid/ready handshake.
module key_expansion_iter #(
    parameter int unsigned NR = 10
) (
    input logic           clk,
    input logic           rst,
    key_expansion_if.slave bus
);
    localparam logic [3:0] LAST = 4'(NR);

    // AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return SBOX[base +: 8];
    endfunction

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [7:0]   rcon_q, rcon_d;

    logic [31:0]  w0, w1, w2, w3, rot, t;
    logic [31:0]  n0, n1, n2, n3;
    logic [7:0]   rcon_next;

    assign w0  = key_q[127:96];
    assign w1  = key_q[95:64];
    assign w2  = key_q[63:32];
    assign w3  = key_q[31:0];
    assign rot = {w3[23:0], w3[31:24]};
    assign t   = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
                  sub_byte(rot[15:8]), sub_byte(rot[7:0])} ^ {rcon_q, 24'h0};
    assign n0  = w0 ^ t;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;

    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rcon_d  = rcon_q;
        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (bus.start) begin
                    key_d   = bus.cipher_key;
                    idx_d   = 4'd0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    rcon_d  = 8'h01;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.key_ready) begin
                    if (idx_q == LAST) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        key_d  = {n0, n1, n2, n3};
                        idx_d  = idx_q + 4'd1;
                        rcon_d = rcon_next;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            key_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rcon_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rcon_q  <= rcon_d;
        end
    end

    assign bus.round_key = key_q;
    assign bus.round_idx = idx_q;
    assign bus.key_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_key_expansion_iter.sv
// Directed bench for key_expansion_iter using FIPS-197 and all-zero key vectors.
module tb_key_expansion_iter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [127:0] fips_keys [11];
    logic [127:0] fips_key;
    logic [127:0] other_key;

    key_expansion_if kif ();

    key_expansion_iter #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (kif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        kif.start      = 1'b0;
        kif.cipher_key = '0;
        kif.key_ready  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (kif.round_key !== 128'h0 || kif.round_idx !== 4'd0 || kif.key_valid !== 1'b0 ||
            kif.busy !== 1'b0 || kif.done !== 1'b0) begin
            errors++;
            $display("FAIL reset: got key=%h idx=%0d valid=%b busy=%b done=%b expected all zero",
                     kif.round_key, kif.round_idx, kif.key_valid, kif.busy, kif.done);
        end
    endtask

    task automatic test_fips();
        kif.key_ready  = 1'b1;
        kif.cipher_key = fips_key;
        kif.start      = 1'b1;
        tick();
        kif.start = 1'b0;
        kif.cipher_key = '0;
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) tick();
            checks++;
            if (kif.round_key !== fips_keys[i] || kif.round_idx !== 4'(i) ||
                kif.key_valid !== 1'b1 || kif.busy !== 1'b1 || kif.done !== 1'b0) begin
                errors++;
                $display("FAIL fips_key%0d: got key=%h idx=%0d valid=%b busy=%b expected key=%h",
                         i, kif.round_key, kif.round_idx, kif.key_valid, kif.busy, fips_keys[i]);
            end
        end
        tick();
        checks++;
        if (kif.done !== 1'b1 || kif.key_valid !== 1'b0 || kif.busy !== 1'b0) begin
            errors++;
            $display("FAIL fips_done: got done=%b valid=%b busy=%b expected done=1 valid=0 busy=0",
                     kif.done, kif.key_valid, kif.busy);
        end
        tick();
        checks++;
        if (kif.done !== 1'b0 || kif.key_valid !== 1'b0) begin
            errors++;
            $display("FAIL fips_done_pulse: got done=%b valid=%b expected 0 0",
                     kif.done, kif.key_valid);
        end
    endtask

    task automatic test_zero_key();
        bit seen_done;
        kif.key_ready  = 1'b1;
        kif.cipher_key = 128'h0;
        kif.start      = 1'b1;
        tick();
        kif.start = 1'b0;
        tick();
        checks++;
        if (kif.round_key !== 128'h62636363626363636263636362636363 || kif.round_idx !== 4'd1) begin
            errors++;
            $display("FAIL zero_key1: got key=%h idx=%0d expected 62636363626363636263636362636363",
                     kif.round_key, kif.round_idx);
        end
        tick();
        checks++;
        if (kif.round_key !== 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa || kif.round_idx !== 4'd2) begin
            errors++;
            $display("FAIL zero_key2: got key=%h idx=%0d expected 9b9898c9f9fbfbaa9b9898c9f9fbfbaa",
                     kif.round_key, kif.round_idx);
        end
        seen_done = 1'b0;
        for (int n = 0; n < 20 && !seen_done; n++) begin
            tick();
            if (kif.done === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL zero_done: got no done within 20 cycles expected done pulse");
        end
        tick();
    endtask

    task automatic test_stall();
        kif.key_ready  = 1'b1;
        kif.cipher_key = fips_key;
        kif.start      = 1'b1;
        tick();
        kif.start = 1'b0;
        tick();
        tick();
        tick();
        kif.key_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (kif.round_key !== fips_keys[3] || kif.round_idx !== 4'd3 ||
                kif.key_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: got key=%h idx=%0d valid=%b expected key=%h idx=3",
                         c, kif.round_key, kif.round_idx, kif.key_valid, fips_keys[3]);
            end
        end
        kif.key_ready = 1'b1;
        for (int i = 4; i <= 10; i++) begin
            tick();
            checks++;
            if (kif.round_key !== fips_keys[i] || kif.round_idx !== 4'(i)) begin
                errors++;
                $display("FAIL stall_key%0d: got key=%h idx=%0d expected key=%h",
                         i, kif.round_key, kif.round_idx, fips_keys[i]);
            end
        end
        tick();
        checks++;
        if (kif.done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: got done=%b expected 1", kif.done);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        kif.key_ready  = 1'b1;
        kif.cipher_key = fips_key;
        kif.start      = 1'b1;
        tick();
        kif.start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 4) begin
                kif.cipher_key = other_key;
                kif.start      = 1'b1;
            end else begin
                kif.start = 1'b0;
            end
            tick();
            checks++;
            if (kif.round_key !== fips_keys[i] || kif.round_idx !== 4'(i)) begin
                errors++;
                $display("FAIL ignore_key%0d: got key=%h idx=%0d expected key=%h",
                         i, kif.round_key, kif.round_idx, fips_keys[i]);
            end
        end
        kif.start = 1'b0;
        tick();
        checks++;
        if (kif.done !== 1'b1) begin
            errors++;
            $display("FAIL ignore_done: got done=%b expected 1", kif.done);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit bad_done;
        kif.key_ready  = 1'b1;
        kif.cipher_key = fips_key;
        kif.start      = 1'b1;
        tick();
        kif.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (kif.round_idx !== 4'd6) begin
            errors++;
            $display("FAIL rstmid_pre: got idx=%0d expected 6", kif.round_idx);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (kif.round_key !== 128'h0 || kif.round_idx !== 4'd0 || kif.key_valid !== 1'b0 ||
            kif.busy !== 1'b0 || kif.done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: got key=%h idx=%0d valid=%b busy=%b done=%b expected zero",
                     kif.round_key, kif.round_idx, kif.key_valid, kif.busy, kif.done);
        end
        tick();
        rst = 1'b0;
        bad_done = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (kif.done !== 1'b0 || kif.key_valid !== 1'b0) bad_done = 1'b1;
        end
        checks++;
        if (bad_done) begin
            errors++;
            $display("FAIL rstmid_quiet: got done or valid after reset expected both 0");
        end
        kif.start = 1'b1;
        tick();
        kif.start = 1'b0;
        checks++;
        if (kif.round_key !== fips_keys[0] || kif.round_idx !== 4'd0 || kif.key_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_key0: got key=%h idx=%0d valid=%b expected key=%h",
                     kif.round_key, kif.round_idx, kif.key_valid, fips_keys[0]);
        end
        tick();
        checks++;
        if (kif.round_key !== fips_keys[1] || kif.round_idx !== 4'd1) begin
            errors++;
            $display("FAIL rstmid_key1: got key=%h idx=%0d expected key=%h",
                     kif.round_key, kif.round_idx, fips_keys[1]);
        end
        for (int n = 0; n < 10; n++) tick();
        checks++;
        if (kif.done !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_done: got done=%b expected 1", kif.done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        kif.key_ready  = 1'b1;
        kif.cipher_key = 128'h0;
        kif.start      = 1'b1;
        tick();
        kif.start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        checks++;
        if (kif.done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got done=%b expected 1", kif.done);
        end
        kif.cipher_key = fips_key;
        kif.start      = 1'b1;
        tick();
        kif.start = 1'b0;
        checks++;
        if (kif.round_key !== fips_keys[0] || kif.key_valid !== 1'b1 || kif.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_key0: got key=%h valid=%b busy=%b expected key=%h valid=1 busy=1",
                     kif.round_key, kif.key_valid, kif.busy, fips_keys[0]);
        end
        tick();
        checks++;
        if (kif.round_key !== fips_keys[1] || kif.round_idx !== 4'd1) begin
            errors++;
            $display("FAIL b2b_key1: got key=%h idx=%0d expected key=%h",
                     kif.round_key, kif.round_idx, fips_keys[1]);
        end
        for (int n = 0; n < 11; n++) tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        fips_key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        other_key = 128'h000102030405060708090a0b0c0d0e0f;
        fips_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        test_reset();
        test_fips();
        test_zero_key();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
